multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Main control state machine for the multicycle core. Sits directly upstream of the conditional logic unit.
- Decodes the instruction register fields (Op, Funct, Rd) and sequences fetch/decode/execute/writeback.
- Produces the raw, unconditioned RegW, MemW, FlagW, NextPC and PCS strobes. The conditional logic unit gates these with the condition check.
- Also drives all datapath mux selects and the ALU operation.

Parameters:
- MEM_WAIT, 1, when 1 the FETCH, MEMREAD and MEMWRITE states hold until MemReady=1; when 0 MemReady is ignored and treated as always 1.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- Op  input  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- Funct  input  6  Instr[25:20]: [5]=I (immediate), [4:1]=cmd, [0]=S (memory: [0]=L).
- Rd  input  4  Instr[15:12].
- MemReady  input  1  memory access completes this cycle.
- IRWrite  output  1  load instruction register.
- NextPC  output  1  unconditional PC update (fetch increment).
- PCS  output  1  PC-write request, subject to condition: Branch state, or ALUWB/MEMWB with Rd=15.
- RegW  output  1  register-file write request (raw).
- MemW  output  1  memory write request (raw).
- FlagW  output  2  [1]=NZ update, [0]=CV update (raw).
- AdrSrc  output  1  0=PC, 1=ALU result register.
- ALUSrcA  output  1  0=RD1, 1=PC.
- ALUSrcB  output  2  00=RD2/shifted, 01=ExtImm, 10=constant 4.
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALU result direct.
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- ImmSrc  output  2  equals Op (combinational).
- RegSrc  output  2  [0]=(Op==10), [1]=(Op==01) (combinational).
- State  output  4  current state encoding, for debug and bench.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
- One-hot or Moore outputs decoded from the registered state. The state register updates on the rising CLK edge.
- RESET asserted: state=FETCH immediately (asynchronous). While RESET=1, IRWrite, NextPC, PCS, RegW, MemW and FlagW are forced to 0; selects take their FETCH values.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUop=add. IRWrite and NextPC are asserted only in the cycle where MemReady=1 (or MEM_WAIT=0). Next state is DECODE on that cycle; otherwise stay in FETCH.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, add. Transitions:
  - Op=01 -> MEMADR
  - Op=00, Funct[5]=0 -> EXECUTER
  - Op=00, Funct[5]=1 -> EXECUTEI
  - Op=10 -> BRANCH
  - Op=11 -> FETCH, with no strobes asserted.
- MEMADR: ALUSrcA=0, ALUSrcB=01, add. Funct[0]=1 -> MEMREAD, else -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady, then -> MEMWB.
- MEMWB: ResultSrc=01, RegW=1, PCS=(Rd==15). -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00. MemW=1 in every cycle of this state; the memory samples it on MemReady. Hold until MemReady, then -> FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALU decode active. -> ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALU decode active. -> ALUWB.
- ALU decode (EXECUTER/EXECUTEI/ALUWB only), by cmd:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - 1010 CMP: SUB with NoWrite=1.
  - Any other cmd: ADD with NoWrite=1.
  - Flag updates: FlagW[1]=Funct[0]; FlagW[0]=Funct[0]&(op is ADD or SUB).
  - FlagW is asserted in EXECUTER/EXECUTEI only; it is 00 in all other states.
  - Outside ALU decode, ALUControl=00.
- ALUWB: ResultSrc=00, RegW=~NoWrite, PCS=(Rd==15)&~NoWrite. -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, add, PCS=1. -> FETCH.
- Op, Funct and Rd are sampled combinationally from the IR and are stable after FETCH. The FSM does not latch them.
- RESET mid-instruction abandons it; no strobes are asserted in the reset cycle.

Test Plan:
- Reset asserted mid-EXECUTER -> State=0 asynchronously, all strobes 0. Release with MemReady=1 -> IRWrite=1, NextPC=1, next State=1.
- ADDS R1 (Op=00, Funct=101001, Rd=1) -> states 0,1,7,8. In state 7: ALUControl=00, FlagW=11. In state 8: RegW=1, PCS=0.
- CMP register (Funct=010101) -> states 0,1,6,8. FlagW=11 in state 6; in state 8 RegW=0 and PCS=0.
- LDR to PC (Op=01, Funct[0]=1, Rd=15) with MemReady low for 2 cycles in MEMREAD -> States 0,1,2,3,3,3,4. In state 4: RegW=1, PCS=1.
- STR (Funct[0]=0) -> states 0,1,2,5. MemW=1 only in state 5, RegW=0 throughout.
- Branch (Op=10) -> states 0,1,9,0 with PCS=1 only in 9. Op=11 -> states 0,1,0 with no strobes.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle main FSM and the datapath /
// conditional logic unit. Instruction fields and MemReady come in; strobes and selects go out.
interface multicycle_control_fsm_if;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       MemReady;
   logic       IRWrite;
   logic       NextPC;
   logic       PCS;
   logic       RegW;
   logic       MemW;
   logic [1:0] FlagW;
   logic       AdrSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ALUControl;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic [3:0] State;

   modport master (
      input  Op, Funct, Rd, MemReady,
      output IRWrite, NextPC, PCS, RegW, MemW, FlagW,
             AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
             ImmSrc, RegSrc, State
   );

   modport slave (
      output Op, Funct, Rd, MemReady,
      input  IRWrite, NextPC, PCS, RegW, MemW, FlagW,
             AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
             ImmSrc, RegSrc, State
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle core: sequences fetch/decode/execute/writeback
// and emits raw (unconditioned) write strobes plus all datapath selects.
module multicycle_control_fsm #(
   parameter bit MEM_WAIT = 1'b1
) (
   input  logic                          CLK,
   input  logic                          RESET,
   multicycle_control_fsm_if.master      bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   state_t     state;
   state_t     nextState;
   logic       memReady;
   logic [3:0] cmd;
   logic       aluDecode;
   logic [1:0] aluOp;
   logic       noWrite;
   logic       addSub;
   logic       rdIsPc;

   logic       irWrite;
   logic       nextPc;
   logic       pcs;
   logic       regW;
   logic       memW;
   logic [1:0] flagW;
   logic       adrSrc;
   logic       aluSrcA;
   logic [1:0] aluSrcB;
   logic [1:0] resultSrc;
   logic [1:0] aluControl;

   assign memReady  = MEM_WAIT ? bus.MemReady : 1'b1;
   assign cmd       = bus.Funct[4:1];
   assign rdIsPc    = (bus.Rd == 4'd15);
   assign aluDecode = (state == EXECUTER) || (state == EXECUTEI) || (state == ALUWB);

   // State register: reset abandons any in-flight instruction immediately
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= FETCH;
      else       state <= nextState;
   end

   // ALU command decode; unknown commands become a non-writing ADD
   always_comb begin
      aluOp   = ALU_ADD;
      noWrite = 1'b0;
      case (cmd)
         4'b0100: aluOp = ALU_ADD;
         4'b0010: aluOp = ALU_SUB;
         4'b0000: aluOp = ALU_AND;
         4'b1100: aluOp = ALU_ORR;
         4'b1010: begin
            aluOp   = ALU_SUB;
            noWrite = 1'b1;
         end
         default: begin
            aluOp   = ALU_ADD;
            noWrite = 1'b1;
         end
      endcase
   end

   assign addSub = (aluOp == ALU_ADD) || (aluOp == ALU_SUB);

   always_comb begin
      nextState = state;
      case (state)
         FETCH:    if (memReady) nextState = DECODE;
         DECODE: begin
            case (bus.Op)
               2'b00:   nextState = bus.Funct[5] ? EXECUTEI : EXECUTER;
               2'b01:   nextState = MEMADR;
               2'b10:   nextState = BRANCH;
               default: nextState = FETCH;
            endcase
         end
         MEMADR:   nextState = bus.Funct[0] ? MEMREAD : MEMWRITE;
         MEMREAD:  if (memReady) nextState = MEMWB;
         MEMWB:    nextState = FETCH;
         MEMWRITE: if (memReady) nextState = FETCH;
         EXECUTER: nextState = ALUWB;
         EXECUTEI: nextState = ALUWB;
         ALUWB:    nextState = FETCH;
         BRANCH:   nextState = FETCH;
         default:  nextState = FETCH;
      endcase
   end

   always_comb begin
      irWrite    = 1'b0;
      nextPc     = 1'b0;
      pcs        = 1'b0;
      regW       = 1'b0;
      memW       = 1'b0;
      flagW      = 2'b00;
      adrSrc     = 1'b0;
      aluSrcA    = 1'b0;
      aluSrcB    = 2'b00;
      resultSrc  = 2'b00;
      aluControl = aluDecode ? aluOp : ALU_ADD;
      case (state)
         FETCH: begin
            aluSrcA   = 1'b1;
            aluSrcB   = 2'b10;
            resultSrc = 2'b10;
            irWrite   = memReady;
            nextPc    = memReady;
         end
         DECODE: begin
            aluSrcA   = 1'b1;
            aluSrcB   = 2'b10;
            resultSrc = 2'b10;
         end
         MEMADR: begin
            aluSrcB = 2'b01;
         end
         MEMREAD: begin
            adrSrc = 1'b1;
         end
         MEMWB: begin
            resultSrc = 2'b01;
            regW      = 1'b1;
            pcs       = rdIsPc;
         end
         MEMWRITE: begin
            adrSrc = 1'b1;
            memW   = 1'b1;
         end
         EXECUTER: begin
            flagW = {bus.Funct[0], bus.Funct[0] & addSub};
         end
         EXECUTEI: begin
            aluSrcB = 2'b01;
            flagW   = {bus.Funct[0], bus.Funct[0] & addSub};
         end
         ALUWB: begin
            regW = ~noWrite;
            pcs  = rdIsPc & ~noWrite;
         end
         BRANCH: begin
            aluSrcB   = 2'b01;
            resultSrc = 2'b10;
            pcs       = 1'b1;
         end
         default: ;
      endcase
      // State is already FETCH during reset, but the MemReady-driven strobes must still be held off
      if (RESET) begin
         irWrite = 1'b0;
         nextPc  = 1'b0;
         pcs     = 1'b0;
         regW    = 1'b0;
         memW    = 1'b0;
         flagW   = 2'b00;
      end
   end

   assign bus.IRWrite    = irWrite;
   assign bus.NextPC     = nextPc;
   assign bus.PCS        = pcs;
   assign bus.RegW       = regW;
   assign bus.MemW       = memW;
   assign bus.FlagW      = flagW;
   assign bus.AdrSrc     = adrSrc;
   assign bus.ALUSrcA    = aluSrcA;
   assign bus.ALUSrcB    = aluSrcB;
   assign bus.ResultSrc  = resultSrc;
   assign bus.ALUControl = aluControl;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
   assign bus.State      = state;

endmodule
